ex_div: RTL and testbench
=========================

# ex_div

Iterative 32-bit radix-2 divider owned by the execute stage. It consumes the operands that the ID/EX register presents on ex_reg1/ex_reg2 for DIV/DIVU, and returns a 64-bit {remainder, quotient} pair destined for HI/LO. While it is busy, the execute stage holds its pipeline stall request. It computes one quotient bit per cycle and supports cancellation when the pipeline is flushed.

## Interface
Parameters: none.

- clk  input  1  clock; all state changes on rising edge
- rst  input  1  reset rst, synchronous, active-high; clock clk
- signed_div  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start
- opdata1  input  32  dividend; sampled with start
- opdata2  input  32  divisor; sampled with start
- start  input  1  request; held high by EX until ready is seen
- annul  input  1  cancel in-flight operation (flush)
- result  output  64  {remainder[63:32], quotient[31:0]}; valid while ready=1, else 0
- ready  output  1  result valid

## Operation
- States: IDLE, BYZERO, ON, END. Reset value: IDLE, ready=0, result=0, cnt=0.
- IDLE:
  - start=1, annul=0, opdata2==0 → BYZERO.
  - start=1, annul=0, opdata2!=0 → ON. Latch the operands. Load the working dividend register (65 bits) with {32'b0, |opdata1|, 1'b0}. cnt=0.
  - start=0 or annul=1 → stay in IDLE.
- ON, cnt<32: one restoring step per cycle. Compute diff = dividend[64:32] − {1'b0, |opdata2|}.
  - If diff is negative, shift dividend left 1 and set bit0=0.
  - Otherwise, dividend = {diff[31:0], dividend[31:0], 1'b1}.
  - cnt += 1.
- ON, cnt==32: apply sign correction, register result, set ready=1, → END.
  - Quotient is negated if signed and op1/op2 signs differ.
  - Remainder is negated if signed and op1 is negative.
- ON, annul=1: annul has priority over the step. → IDLE, ready=0, result=0, partial work discarded.
- BYZERO: → END with result=0, ready=1.
- END: hold result and ready while start=1. start=0 → IDLE, ready=0, result=0.
- Magnitudes: |x| is the two's-complement negation when signed_div=1 and x[31]=1; otherwise x unchanged.
- Semantics (MIPS): quotient truncates toward zero; remainder takes the sign of the dividend.
- 0x80000000 / 0xFFFFFFFF signed: quotient 0x80000000 (wraps), remainder 0. No trap.
- Operand changes after the start cycle are ignored.

## Timing
- Edge E0 samples start in IDLE.
- Non-zero divisor:
  - Edges E1..E32 perform the 32 steps.
  - E33 registers result; ready=1 is visible after E33, so latency is 33 cycles.
- Zero divisor: ready=1 after E1.
- The EX stall request is start & ~ready (generated in EX, not here).
- Back-to-back divides need start low for at least one cycle. That cycle is the END→IDLE transition, so minimum issue interval is 35 cycles.
- annul in END is ignored. The result is released by start=0.
- rst in any state → IDLE on the next edge. Reset overrides annul and start.

## Configuration
- EX_DIV_SIGNED_EN defined: signed_div is honoured as above.
- EX_DIV_SIGNED_EN undefined:
  - signed_div is ignored and treated as 0.
  - Abs/negate logic is not synthesized.
  - All operations are unsigned.

## Test plan
- Unsigned 100 / 7, start held → ready rises 33 cycles after start edge; result = {32'd2, 32'd14}.
- Signed 0xFFFFFFF9 / 2 (−7/2) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. With EX_DIV_SIGNED_EN undefined, the same stimulus gives quotient 0x7FFFFFFC, remainder 1.
- Divisor 0 → ready=1 after E1; result = 0. Drop start → ready=0 and result=0 next edge.
- Signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0, no hang.
- Start 100/7, assert annul at cycle 10 → IDLE next edge, ready never rises. Then start 9/3 → result {0, 3}.
- Start 100/7, assert rst at cycle 20 → ready=0 and result=0. Re-issue completes correctly in 33 cycles.

Source files
------------

// File: rtl/ex_div.sv
// ex_div: iterative 32-bit radix-2 restoring divider for DIV/DIVU, one quotient bit per cycle.
// Define EX_DIV_SIGNED_EN to honour signed_div; otherwise every operation is unsigned.
module ex_div (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div,
    input  logic [31:0] opdata1,
    input  logic [31:0] opdata2,
    input  logic        start,
    input  logic        annul,
    output logic [63:0] result,
    output logic        ready
);

    typedef enum logic [1:0] {S_IDLE, S_BYZERO, S_ON, S_END} state_t;

    state_t      r_state, w_state_nxt;
    logic [64:0] r_dividend, w_dividend_nxt;
    logic [5:0]  r_cnt, w_cnt_nxt;
    logic [31:0] r_divisor, w_divisor_nxt;
    logic [63:0] r_result, w_result_nxt;
    logic        r_ready, w_ready_nxt;
    logic [32:0] w_diff;
    logic [31:0] w_abs1, w_abs2, w_quot, w_rem;
    logic        w_accept;

    assign w_accept = (r_state == S_IDLE) && start && !annul;

`ifdef EX_DIV_SIGNED_EN
    logic r_neg_q, r_neg_r;

    assign w_abs1 = (signed_div && opdata1[31]) ? -opdata1 : opdata1;
    assign w_abs2 = (signed_div && opdata2[31]) ? -opdata2 : opdata2;
    assign w_quot = r_neg_q ? -r_dividend[31:0]  : r_dividend[31:0];
    assign w_rem  = r_neg_r ? -r_dividend[64:33] : r_dividend[64:33];

    // Sign corrections are decided from the raw operands at the accept edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (w_accept) begin
            r_neg_q <= signed_div & (opdata1[31] ^ opdata2[31]);
            r_neg_r <= signed_div & opdata1[31];
        end
    end
`else
    logic w_unused_signed;

    assign w_unused_signed = signed_div;
    assign w_abs1 = opdata1;
    assign w_abs2 = opdata2;
    assign w_quot = r_dividend[31:0];
    assign w_rem  = r_dividend[64:33];
`endif

    assign w_diff = r_dividend[64:32] - {1'b0, r_divisor};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_dividend <= '0;
            r_cnt      <= '0;
            r_divisor  <= '0;
            r_result   <= '0;
            r_ready    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_dividend <= w_dividend_nxt;
            r_cnt      <= w_cnt_nxt;
            r_divisor  <= w_divisor_nxt;
            r_result   <= w_result_nxt;
            r_ready    <= w_ready_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_dividend_nxt = r_dividend;
        w_cnt_nxt      = r_cnt;
        w_divisor_nxt  = r_divisor;
        w_result_nxt   = r_result;
        w_ready_nxt    = r_ready;
        case (r_state)
            S_IDLE: begin
                w_ready_nxt  = 1'b0;
                w_result_nxt = '0;
                if (w_accept) begin
                    if (opdata2 == '0) begin
                        w_state_nxt = S_BYZERO;
                    end else begin
                        w_state_nxt    = S_ON;
                        w_divisor_nxt  = w_abs2;
                        w_dividend_nxt = {32'b0, w_abs1, 1'b0};
                        w_cnt_nxt      = '0;
                    end
                end
            end
            S_BYZERO: begin
                w_state_nxt  = S_END;
                w_result_nxt = '0;
                w_ready_nxt  = 1'b1;
            end
            S_ON: begin
                if (annul) begin
                    w_state_nxt  = S_IDLE;
                    w_cnt_nxt    = '0;
                    w_result_nxt = '0;
                    w_ready_nxt  = 1'b0;
                end else if (r_cnt != 6'd32) begin
                    // Restoring step: keep the shifted remainder when the trial subtract underflows.
                    if (w_diff[32]) begin
                        w_dividend_nxt = {r_dividend[63:0], 1'b0};
                    end else begin
                        w_dividend_nxt = {w_diff[31:0], r_dividend[31:0], 1'b1};
                    end
                    w_cnt_nxt = r_cnt + 6'd1;
                end else begin
                    w_state_nxt  = S_END;
                    w_result_nxt = {w_rem, w_quot};
                    w_ready_nxt  = 1'b1;
                end
            end
            S_END: begin
                if (!start) begin
                    w_state_nxt  = S_IDLE;
                    w_result_nxt = '0;
                    w_ready_nxt  = 1'b0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign result = r_result;
    assign ready  = r_ready;

endmodule

// File: tb/tb_ex_div.sv
// tb_ex_div: vector table, hand-written annul/reset/END sequences and random divides for ex_div.
`timescale 1ns/1ps
module tb_ex_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div;
    logic [31:0] opdata1;
    logic [31:0] opdata2;
    logic        start;
    logic        annul;
    logic [63:0] result;
    logic        ready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ex_div dut (
        .clk        (clk),
        .rst        (rst),
        .signed_div (signed_div),
        .opdata1    (opdata1),
        .opdata2    (opdata2),
        .start      (start),
        .annul      (annul),
        .result     (result),
        .ready      (ready)
    );

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] q, input logic [31:0] r, input int lat);
        vec_t v;
        v.sgn = sgn; v.a = a; v.b = b; v.q = q; v.r = r; v.lat = lat;
        vecs.push_back(v);
    endtask

    task automatic check64(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Reference: MIPS DIV/DIVU from magnitudes with plain integer division.
    function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        logic              s;
        longint unsigned   ma, mb, q, r;
        logic [31:0]       q32, r32;
`ifdef EX_DIV_SIGNED_EN
        s = sgn;
`else
        s = 1'b0;
`endif
        if (b == 32'd0) return 64'd0;
        ma = {32'b0, a};
        mb = {32'b0, b};
        if (s && a[31]) ma = 64'h1_0000_0000 - ma;
        if (s && b[31]) mb = 64'h1_0000_0000 - mb;
        q = ma / mb;
        r = ma % mb;
        q32 = q[31:0];
        r32 = r[31:0];
        if (s && (a[31] ^ b[31])) q32 = -q32;
        if (s && a[31]) r32 = -r32;
        return {r32, q32};
    endfunction

    // Issue one divide and hold start until ready; operands are scrambled after the accept edge.
    task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           output logic [63:0] res, output int lat, output int leak);
        leak = 0;
        lat  = -1;
        res  = '0;
        @(negedge clk);
        signed_div = sgn; opdata1 = a; opdata2 = b; start = 1'b1;
        @(posedge clk); #1;
        signed_div = 1'($urandom);
        opdata1    = $urandom;
        opdata2    = $urandom;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk); #1;
            if (ready) begin
                lat = n;
                res = result;
                break;
            end
            if (result !== 64'd0) leak = 1;
        end
    endtask

    task automatic release_chk(input string tag);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        check64({tag, " released result"}, result, 64'd0);
        check_int({tag, " released ready"}, int'(ready), 0);
    endtask

    task automatic full_div(input string tag, input logic sgn, input logic [31:0] a,
                            input logic [31:0] b, input logic [63:0] exp, input int exp_lat);
        logic [63:0] res;
        int          lat, leak;
        run_div(sgn, a, b, res, lat, leak);
        check64({tag, " result"}, res, exp);
        check_int({tag, " latency"}, lat, exp_lat);
        check_int({tag, " early result"}, leak, 0);
        release_chk(tag);
    endtask

    initial begin
        logic [63:0] res;
        int          lat, leak, seen;
        logic        sgn;
        logic [31:0] a, b;

        add_vec(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33);
        add_vec(1'b0, 32'd5, 32'd10, 32'd0, 32'd5, 33);
        add_vec(1'b0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 33);
        add_vec(1'b0, 32'd1234, 32'd0, 32'd0, 32'd0, 1);
        add_vec(1'b1, 32'd100, 32'd7, 32'd14, 32'd2, 33);
`ifdef EX_DIV_SIGNED_EN
        add_vec(1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 33);
        add_vec(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 33);
        add_vec(1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 33);
        add_vec(1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 33);
`else
        add_vec(1'b1, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, 32'd1, 33);
        add_vec(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 33);
        add_vec(1'b1, 32'd7, 32'hFFFFFFFE, 32'd0, 32'd7, 33);
        add_vec(1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd0, 32'hFFFFFFF9, 33);
`endif
        add_vec(1'b1, 32'hFFFFFFFF, 32'd0, 32'd0, 32'd0, 1);

        rst = 1'b1; start = 1'b0; annul = 1'b0; signed_div = 1'b0;
        opdata1 = '0; opdata2 = '0;
        repeat (3) @(posedge clk);
        #1;
        check64("reset result", result, 64'd0);
        check_int("reset ready", int'(ready), 0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            full_div($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].a, vecs[i].b,
                     {vecs[i].r, vecs[i].q}, vecs[i].lat);
        end

        // Annul while in progress: no result may appear, then a fresh divide works.
        @(negedge clk);
        signed_div = 1'b0; opdata1 = 32'd100; opdata2 = 32'd7; start = 1'b1;
        @(posedge clk);
        repeat (9) @(posedge clk);
        @(negedge clk);
        annul = 1'b1;
        @(posedge clk); #1;
        check_int("annul ready", int'(ready), 0);
        check64("annul result", result, 64'd0);
        @(negedge clk);
        annul = 1'b0; start = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (ready) seen = 1;
        end
        check_int("annul no ready", seen, 0);
        full_div("after annul", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33);

        // Synchronous reset mid-divide.
        @(negedge clk);
        signed_div = 1'b0; opdata1 = 32'd100; opdata2 = 32'd7; start = 1'b1;
        @(posedge clk);
        repeat (20) @(posedge clk);
        @(negedge clk);
        rst = 1'b1; annul = 1'b1;
        @(posedge clk); #1;
        check_int("rst mid ready", int'(ready), 0);
        check64("rst mid result", result, 64'd0);
        @(negedge clk);
        rst = 1'b0; annul = 1'b0; start = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (ready) seen = 1;
        end
        check_int("rst no ready", seen, 0);
        full_div("after rst", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);

        // In END: annul is ignored and the result holds while start stays high.
        run_div(1'b0, 32'd1000, 32'd33, res, lat, leak);
        check64("end result", res, {32'd10, 32'd30});
        @(negedge clk);
        annul = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_int("end annul ready", int'(ready), 1);
        check64("end annul result", result, {32'd10, 32'd30});
        @(negedge clk);
        annul = 1'b0;
        release_chk("end annul");

        // Reset from END overrides a held start.
        run_div(1'b0, 32'd77, 32'd0, res, lat, leak);
        check_int("byzero latency", lat, 1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check_int("rst end ready", int'(ready), 0);
        check64("rst end result", result, 64'd0);
        @(negedge clk);
        rst = 1'b0; start = 1'b0;

        for (int k = 0; k < 150; k++) begin
            sgn = 1'($urandom);
            a   = $urandom;
            case ($urandom_range(0, 4))
                0: b = $urandom_range(0, 15);
                1: b = $urandom;
                2: b = ($urandom_range(0, 1) != 0) ? 32'hFFFFFFFF : 32'h80000000;
                3: b = a >> $urandom_range(0, 31);
                default: b = -($urandom_range(1, 9));
            endcase
            if ($urandom_range(0, 9) == 0) a = 32'h80000000;
            full_div($sformatf("rand%0d", k), sgn, a, b, model(sgn, a, b), (b == 32'd0) ? 1 : 33);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
